mdio_mgmt_arbiter: RTL and testbench

Shares one Clause-22 MDIO management interface between four requesters (per-port PHY management agents for rgmii_0..3). Arbitration is round-robin. The block serialises the granted read or write into a standard MDIO frame, generates MDC from the system clock, and drives or releases the MDIO pad. It sits between the PS-side management logic and one external MDIO pin pair.

---
 rtl/mdio_mgmt_arbiter.sv | 158 +++++++++++++++
 tb/tb_mdio_mgmt_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_mgmt_arbiter.sv
// Round-robin arbiter that shares one Clause-22 MDIO master between four
// requesters. The granted request becomes one MDIO frame: preamble, header,
// turnaround and data. MDC is divided down from clk, and the pad is driven
// or released through mdio_o/mdio_t.
module mdio_mgmt_arbiter #(
  parameter int MDC_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  wr,
  input  logic [19:0] phy_addr,
  input  logic [19:0] reg_addr,
  input  logic [63:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  logic [2:0]  state;
  logic [1:0]  rr_ptr;
  logic [7:0]  div;
  logic [5:0]  cnt;
  logic [31:0] sreg;
  logic [15:0] rd_sh;
  logic        is_wr;

  logic [1:0]  win;
  logic [1:0]  cand;
  logic        win_vld;
  logic        div_wrap;
  logic        mdc_rise;
  logic        mdc_fall;

  assign div_wrap = (div == 8'(MDC_DIV - 1));
  assign mdc_rise = div_wrap && !mdc;
  assign mdc_fall = div_wrap && mdc;

  // Round-robin pick: first set req bit after rr_ptr, wrapping back to rr_ptr itself last.
  always_comb begin
    win     = rr_ptr;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Frame sequencer: grant/latch in IDLE, then one frame bit per MDC period; outputs change on MDC fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= 2'd3;
      div    <= '0;
      cnt    <= '0;
      sreg   <= '0;
      rd_sh  <= '0;
      is_wr  <= 1'b0;
      gnt    <= '0;
      done   <= '0;
      rdata  <= '0;
      busy   <= 1'b0;
      mdc    <= 1'b0;
      mdio_o <= 1'b1;
      mdio_t <= 1'b1;
    end else begin
      done <= '0;
      if (state == S_IDLE) begin
        mdc    <= 1'b0;
        mdio_t <= 1'b1;
        div    <= '0;
        if (win_vld) begin
          gnt    <= 4'b0001 << win;
          busy   <= 1'b1;
          rr_ptr <= win;
          is_wr  <= wr[win];
          // ST, OP, PHYAD, REGAD, TA, DATA, MSB first; TA/DATA are only driven for writes.
          sreg   <= {2'b01, (wr[win] ? 2'b01 : 2'b10), phy_addr[5*win +: 5],
                     reg_addr[5*win +: 5], 2'b10, wdata[16*win +: 16]};
          mdio_t <= 1'b0;
          cnt    <= '0;
          if (PREAMBLE_LEN == 0) begin
            state  <= S_HDR;
            mdio_o <= 1'b0;
          end else begin
            state  <= S_PRE;
            mdio_o <= 1'b1;
          end
        end
      end else begin
        div <= div_wrap ? 8'd0 : div + 8'd1;
        if (div_wrap) mdc <= ~mdc;
        if (mdc_rise && state == S_DATA && !is_wr) rd_sh <= {rd_sh[14:0], mdio_i};
        if (mdc_fall) begin
          cnt <= cnt + 6'd1;
          case (state)
            S_PRE: begin
              if (cnt == 6'(PREAMBLE_LEN - 1)) begin
                state  <= S_HDR;
                cnt    <= '0;
                mdio_o <= sreg[31];
              end
            end
            S_HDR: begin
              sreg   <= sreg << 1;
              mdio_o <= sreg[30];
              if (cnt == 6'd13) begin
                state <= S_TA;
                cnt   <= '0;
                if (!is_wr) mdio_t <= 1'b1;
              end
            end
            S_TA: begin
              sreg   <= sreg << 1;
              mdio_o <= sreg[30];
              if (cnt == 6'd1) begin
                state <= S_DATA;
                cnt   <= '0;
              end
            end
            default: begin
              sreg   <= sreg << 1;
              mdio_o <= sreg[30];
              if (cnt == 6'd15) begin
                state  <= S_IDLE;
                cnt    <= '0;
                div    <= '0;
                done   <= gnt;
                gnt    <= '0;
                busy   <= 1'b0;
                mdio_t <= 1'b1;
                mdio_o <= 1'b1;
                if (!is_wr) rdata <= rd_sh;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// Bench for mdio_mgmt_arbiter: scoreboard of expected frame bits and
// completions, a PHY model answering reads, one task per scenario.
module tb_mdio_mgmt_arbiter;

  localparam int DIV = 2;
  localparam int PRE = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, wr, req0;
  logic [19:0] phy_addr, reg_addr;
  logic [63:0] wdata;
  logic        mdio_i, mdio_i0;
  logic [3:0]  gnt, done, gnt0, done0;
  logic [15:0] rdata, rdata0;
  logic        busy, mdc, mdio_o, mdio_t;
  logic        busy0, mdc0, mdio_o0, mdio_t0;

  always #4 clk = ~clk;

  mdio_mgmt_arbiter #(.MDC_DIV(DIV), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i));

  mdio_mgmt_arbiter #(.MDC_DIV(DIV), .PREAMBLE_LEN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .wr(wr), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .gnt(gnt0), .done(done0), .rdata(rdata0),
    .busy(busy0), .mdc(mdc0), .mdio_o(mdio_o0), .mdio_t(mdio_t0), .mdio_i(mdio_i0));

  int checks = 0;
  int failures = 0;

  typedef struct { logic o; logic t; } bit_t;
  typedef struct { logic [3:0] d; logic [15:0] r; } txn_t;
  bit_t exp_bits[$];
  txn_t exp_txn[$];
  bit_t eb;
  txn_t et;

  logic [15:0] model_rdata = '0;
  logic [15:0] phy_word = '0;
  logic [15:0] phy_shift = '0;
  bit          mon_en = 1'b0;
  int          rise_k = 0, last_rise = 0, cyc = 0;
  logic        mdc_prev = 1'b0;
  logic [3:0]  gnt_prev = '0;

  assign mdio_i  = phy_shift[15];
  assign mdio_i0 = 1'b1;

  function automatic bit_t mk(input logic o, input logic t);
    bit_t b;
    b.o = o;
    b.t = t;
    return b;
  endfunction

  // Queue the expected pad activity and completion for one frame on the main instance.
  task automatic push_frame(input bit w, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] d, input logic [3:0] onehot);
    txn_t t;
    for (int i = 0; i < PRE; i++) exp_bits.push_back(mk(1'b1, 1'b0));
    exp_bits.push_back(mk(1'b0, 1'b0));
    exp_bits.push_back(mk(1'b1, 1'b0));
    exp_bits.push_back(mk(!w, 1'b0));
    exp_bits.push_back(mk(w, 1'b0));
    for (int i = 4; i >= 0; i--) exp_bits.push_back(mk(pa[i], 1'b0));
    for (int i = 4; i >= 0; i--) exp_bits.push_back(mk(ra[i], 1'b0));
    if (w) begin
      exp_bits.push_back(mk(1'b1, 1'b0));
      exp_bits.push_back(mk(1'b0, 1'b0));
    end else begin
      exp_bits.push_back(mk(1'b0, 1'b1));
      exp_bits.push_back(mk(1'b0, 1'b1));
    end
    for (int i = 15; i >= 0; i--) exp_bits.push_back(w ? mk(d[i], 1'b0) : mk(1'b0, 1'b1));
    if (!w) model_rdata = d;
    t.d = onehot;
    t.r = model_rdata;
    exp_txn.push_back(t);
  endtask

  // Monitor: frame bits at each MDC rise, MDC period, grant one-hot, completions, PHY read data.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (gnt != 0 && gnt_prev == 0) begin
        rise_k = 0;
        phy_shift = phy_word;
      end
      if (gnt != 0) begin
        checks++;
        if ($countones(gnt) != 1) begin
          failures++;
          $display("FAIL gnt_onehot gnt=%b", gnt);
        end
      end
      if (mdc && !mdc_prev) begin
        checks++;
        if (exp_bits.size() == 0) begin
          failures++;
          $display("FAIL bit_extra unexpected mdc rise at cycle %0d", cyc);
        end else begin
          eb = exp_bits.pop_front();
          if (mdio_t !== eb.t) begin
            failures++;
            $display("FAIL bit%0d_mdio_t got %b want %b", rise_k, mdio_t, eb.t);
          end
          if (!eb.t) begin
            checks++;
            if (mdio_o !== eb.o) begin
              failures++;
              $display("FAIL bit%0d_mdio_o got %b want %b", rise_k, mdio_o, eb.o);
            end
          end
        end
        if (rise_k > 0) begin
          checks++;
          if (cyc - last_rise != 2 * DIV) begin
            failures++;
            $display("FAIL mdc_period got %0d want %0d", cyc - last_rise, 2 * DIV);
          end
        end
        last_rise = cyc;
        if (rise_k >= PRE + 16) phy_shift = {phy_shift[14:0], 1'b0};
        rise_k++;
      end
      if (done != 0) begin
        checks++;
        if (exp_txn.size() == 0) begin
          failures++;
          $display("FAIL done_extra done=%b", done);
        end else begin
          et = exp_txn.pop_front();
          if (done !== et.d) begin
            failures++;
            $display("FAIL done_vec got %b want %b", done, et.d);
          end
          checks++;
          if (rdata !== et.r) begin
            failures++;
            $display("FAIL rdata got %h want %h", rdata, et.r);
          end
        end
        checks++;
        if ((done & ~gnt_prev) != 0) begin
          failures++;
          $display("FAIL done_subset done=%b prev_gnt=%b", done, gnt_prev);
        end
      end
    end
    mdc_prev = mdc;
    gnt_prev = gnt;
  end

  task automatic wait_gnt(input bit use0, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((use0 ? gnt0 : gnt) == 0) && n < 2000);
    if ((use0 ? gnt0 : gnt) == 0) n = -1;
  endtask

  task automatic wait_done(input bit use0, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((use0 ? done0 : done) == 0) && n < 2000);
    if ((use0 ? done0 : done) == 0) n = -1;
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    exp_bits.delete();
    exp_txn.delete();
    model_rdata = '0;
    req = '0;
    req0 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0)    begin failures++; $display("FAIL rst_gnt got %b want 0000", gnt); end
    checks++; if (done !== 4'b0)   begin failures++; $display("FAIL rst_done got %b want 0000", done); end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got %h want 0000", rdata); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (mdc !== 1'b0)    begin failures++; $display("FAIL rst_mdc got %b want 0", mdc); end
    checks++; if (mdio_o !== 1'b1) begin failures++; $display("FAIL rst_mdio_o got %b want 1", mdio_o); end
    checks++; if (mdio_t !== 1'b1) begin failures++; $display("FAIL rst_mdio_t got %b want 1", mdio_t); end
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_write;
    int n;
    wr[0] = 1'b1;
    phy_addr[4:0] = 5'h01;
    reg_addr[4:0] = 5'h00;
    wdata[15:0] = 16'h1140;
    push_frame(1'b1, 5'h01, 5'h00, 16'h1140, 4'b0001);
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wr_gnt got %b want 0001", gnt); end
    checks++; if (busy !== 1'b1)   begin failures++; $display("FAIL wr_busy got %b want 1", busy); end
    checks++; if (mdio_t !== 1'b0) begin failures++; $display("FAIL wr_mdio_t got %b want 0", mdio_t); end
    wait_done(1'b0, n);
    req = '0;
    checks++; if (n != 256) begin failures++; $display("FAIL wr_latency got %0d want 256", n); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || busy !== 1'b0 || mdio_t !== 1'b1) begin
      failures++; $display("FAIL wr_idle gnt=%b busy=%b mdio_t=%b want 0000/0/1", gnt, busy, mdio_t);
    end
  endtask

  task automatic test_read;
    int n;
    wr[2] = 1'b0;
    phy_addr[14:10] = 5'h03;
    reg_addr[14:10] = 5'h02;
    phy_word = 16'h0141;
    push_frame(1'b0, 5'h03, 5'h02, 16'h0141, 4'b0100);
    req = 4'b0100;
    wait_gnt(1'b0, n);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rd_gnt got %b want 0100", gnt); end
    wait_done(1'b0, n);
    req = '0;
    checks++; if (n != 256) begin failures++; $display("FAIL rd_latency got %0d want 256", n); end
    checks++; if (rdata !== 16'h0141) begin failures++; $display("FAIL rd_data got %h want 0141", rdata); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [3:0] want;
    test_reset();
    wr = 4'hF;
    for (int i = 0; i < 4; i++) begin
      phy_addr[5*i +: 5] = 5'(i + 8);
      reg_addr[5*i +: 5] = 5'(i + 16);
      wdata[16*i +: 16] = 16'hA5A0 + 16'(i);
    end
    for (int k = 0; k < 5; k++)
      push_frame(1'b1, 5'((k % 4) + 8), 5'((k % 4) + 16), 16'hA5A0 + 16'(k % 4), 4'b0001 << (k % 4));
    req = 4'hF;
    wait_gnt(1'b0, n);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rr_first got %b want 0001", gnt); end
    for (int k = 0; k < 5; k++) begin
      wait_done(1'b0, n);
      checks++; if (n != 256) begin failures++; $display("FAIL rr_latency%0d got %0d want 256", k, n); end
      if (k < 4) begin
        @(negedge clk);
        want = 4'b0001 << ((k + 1) % 4);
        checks++; if (gnt !== want) begin failures++; $display("FAIL rr_next%0d got %b want %b", k, gnt, want); end
        if (k == 3) req = '0;
      end
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rr_idle gnt=%b busy=%b want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    wr[1] = 1'b1;
    phy_addr[9:5] = 5'h07;
    reg_addr[9:5] = 5'h04;
    wdata[31:16] = 16'hBEEF;
    push_frame(1'b1, 5'h07, 5'h04, 16'hBEEF, 4'b0010);
    req = 4'b0010;
    wait_gnt(1'b0, n);
    repeat (226) @(negedge clk);
    checks++; if (mdc !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre mdc=%b busy=%b want 1/1", mdc, busy);
    end
    mon_en = 1'b0;
    exp_bits.delete();
    exp_txn.delete();
    model_rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0)    begin failures++; $display("FAIL mid_gnt got %b want 0000", gnt); end
    checks++; if (mdc !== 1'b0)    begin failures++; $display("FAIL mid_mdc got %b want 0", mdc); end
    checks++; if (mdio_t !== 1'b1) begin failures++; $display("FAIL mid_mdio_t got %b want 1", mdio_t); end
    checks++; if (mdio_o !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_out mdio_o=%b busy=%b want 1/0", mdio_o, busy);
    end
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 4'b0) begin failures++; $display("FAIL mid_done got %b want 0000", done); end
    end
    push_frame(1'b1, 5'h07, 5'h04, 16'hBEEF, 4'b0010);
    mon_en = 1'b1;
    rst_n = 1'b1;
    wait_gnt(1'b0, n);
    checks++; if (gnt !== 4'b0010 || n != 1) begin
      failures++; $display("FAIL mid_regnt got %b after %0d want 0010 after 1", gnt, n);
    end
    wait_done(1'b0, n);
    req = '0;
    checks++; if (n != 256) begin failures++; $display("FAIL mid_latency got %0d want 256", n); end
  endtask

  task automatic test_req_drop;
    int n;
    wr[3] = 1'b1;
    phy_addr[19:15] = 5'h1F;
    reg_addr[19:15] = 5'h1F;
    wdata[63:48] = 16'h8001;
    push_frame(1'b1, 5'h1F, 5'h1F, 16'h8001, 4'b1000);
    req = 4'b1000;
    wait_gnt(1'b0, n);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL drop_gnt got %b want 1000", gnt); end
    repeat (10) @(negedge clk);
    req = '0;
    wdata[63:48] = 16'h0000;
    wait_done(1'b0, n);
    checks++; if (n + 10 != 256) begin failures++; $display("FAIL drop_latency got %0d want 256", n + 10); end
  endtask

  task automatic test_no_preamble;
    int n;
    wr[3] = 1'b1;
    req0 = 4'b1000;
    wait_gnt(1'b1, n);
    checks++; if (gnt0 !== 4'b1000) begin failures++; $display("FAIL np_gnt got %b want 1000", gnt0); end
    checks++; if (mdio_o0 !== 1'b0 || mdio_t0 !== 1'b0) begin
      failures++; $display("FAIL np_first_bit mdio_o=%b mdio_t=%b want 0/0", mdio_o0, mdio_t0);
    end
    wait_done(1'b1, n);
    req0 = '0;
    checks++; if (n != 128) begin failures++; $display("FAIL np_latency got %0d want 128", n); end
    checks++; if (done0 !== 4'b1000) begin failures++; $display("FAIL np_done got %b want 1000", done0); end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req0 = '0;
    wr = '0;
    phy_addr = '0;
    reg_addr = '0;
    wdata = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_mid_frame();
    test_req_drop();
    test_no_preamble();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_bits.size() != 0 || exp_txn.size() != 0) begin
      failures++;
      $display("FAIL leftover bits=%0d txns=%0d want 0/0", exp_bits.size(), exp_txn.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
